uart_loader: RTL

Bus-initiator boot loader driving the CPU-side memory port of `mmu`: vaddr, data, byteena, memWE out, q in. It polls the memory-mapped UART status word, pulls a length-prefixed program image byte by byte from the Rx buffer, and writes it word-by-word into RAM. It then returns a checksum byte through the Tx buffer. It sits in front of `mmu` and is multiplexed with the CPU's memory port (CPU held in reset while `busy`).

---
 rtl/mmio_pkg.sv | 38 +++
 rtl/mmio_uart_port.sv | 65 ++++++
 rtl/uart_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// MMIO addresses, UART status bit positions and FSM encodings shared by the boot loader.
package mmio_pkg;

    localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_0200;
    localparam logic [31:0] UART_TX_ADDR     = 32'h0000_0201;
    localparam logic [31:0] UART_RX_ADDR     = 32'h0000_0202;
    localparam logic [31:0] RANDOM_ADDR      = 32'h0000_0203;

    localparam int STATUS_RX_READY_BIT    = 0;
    localparam int STATUS_TX_BUSY_BIT     = 1;
    localparam int STATUS_RANDOM_BUSY_BIT = 31;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RX,
        LD_RAM_WR,
        LD_TX,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_RX_READ,
        PORT_TX_WR
    } port_state_t;

    // What the loader does after a byte has been handled (and echoed, if enabled).
    typedef enum logic [1:0] {
        ACT_RX,
        ACT_RAM_WR,
        ACT_TX_SUM,
        ACT_TX_ERR
    } loader_act_t;

endpackage

// File: rtl/mmio_uart_port.sv
// Poll-then-access UART sequencer: one Rx read or one Tx write per held request, acked in the access cycle.
// The idle state doubles as the status poll, so a byte costs one poll cycle plus one access cycle.
module mmio_uart_port
    import mmio_pkg::*;
(
    input  logic        clock,
    input  logic        RST,
    input  logic        rx_req,
    input  logic        tx_req,
    input  logic [7:0]  tx_byte,
    input  logic [31:0] q,
    output logic [31:0] vaddr,
    output logic [31:0] data,
    output logic        rx_ack,
    output logic [7:0]  rx_byte,
    output logic        tx_ack
);

    port_state_t state_reg, state_next;

    // Only the status bits and the received byte lane matter here.
    logic unused_q_bits;
    assign unused_q_bits = ^q[31:8];

    always_ff @(posedge clock) begin
        if (RST) begin
            state_reg <= PORT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vaddr      = UART_STATUS_ADDR;
        data       = 32'h0;
        rx_ack     = 1'b0;
        rx_byte    = q[7:0];
        tx_ack     = 1'b0;
        case (state_reg)
            PORT_IDLE: begin
                if (rx_req && q[STATUS_RX_READY_BIT]) begin
                    state_next = PORT_RX_READ;
                end else if (tx_req && !q[STATUS_TX_BUSY_BIT]) begin
                    state_next = PORT_TX_WR;
                end
            end
            PORT_RX_READ: begin
                vaddr      = UART_RX_ADDR;
                rx_ack     = 1'b1;
                state_next = PORT_IDLE;
            end
            PORT_TX_WR: begin
                vaddr      = UART_TX_ADDR;
                data       = {24'h0, tx_byte};
                tx_ack     = 1'b1;
                state_next = PORT_IDLE;
            end
            default: begin
                state_next = PORT_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: pulls a length-prefixed image from the MMIO UART, writes it word-by-word to RAM, replies with a checksum.
// Define UART_LOADER_ECHO_EN to echo every received byte back before polling for the next one.
module uart_loader
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        RST,
    input  logic        start,
    output logic [31:0] vaddr,
    output logic [31:0] data,
    output logic [3:0]  byteena,
    output logic        memWE,
    input  logic [31:0] q,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef UART_LOADER_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    loader_state_t state_reg, state_next;
    logic [1:0]    byte_cnt_reg, byte_cnt_next;
    logic          len_phase_reg, len_phase_next;
    logic [31:0]   shift_reg, shift_next;
    logic [31:0]   len_reg, len_next;
    logic [31:0]   word_cnt_reg, word_cnt_next;
    logic [7:0]    checksum_reg, checksum_next;
    logic [7:0]    tx_byte_reg, tx_byte_next;
    logic          echo_reg, echo_next;
    logic          fail_reg, fail_next;
    loader_act_t   resume_reg, resume_next;
    logic          error_reg, error_next;

    loader_act_t   rx_act, act;
    logic          dispatch_en;

    logic          rx_req, tx_req, rx_ack, tx_ack;
    logic [7:0]    rx_byte;
    logic [31:0]   port_vaddr, port_data;

    assign rx_req = (state_reg == LD_RX);
    assign tx_req = (state_reg == LD_TX);

    mmio_uart_port u_port (
        .clock   (clock),
        .RST     (RST),
        .rx_req  (rx_req),
        .tx_req  (tx_req),
        .tx_byte (tx_byte_reg),
        .q       (q),
        .vaddr   (port_vaddr),
        .data    (port_data),
        .rx_ack  (rx_ack),
        .rx_byte (rx_byte),
        .tx_ack  (tx_ack)
    );

    assign busy  = (state_reg == LD_RX) || (state_reg == LD_RAM_WR) || (state_reg == LD_TX);
    assign done  = (state_reg == LD_DONE);
    assign error = error_reg;

    // The RAM write cycle takes the bus; every other cycle belongs to the UART sequencer.
    always_comb begin
        vaddr   = port_vaddr;
        data    = port_data;
        byteena = 4'h0;
        memWE   = 1'b0;
        if (state_reg == LD_RAM_WR) begin
            vaddr   = BASE_ADDR + (word_cnt_reg << 2);
            data    = shift_reg;
            byteena = 4'hF;
            memWE   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (RST) begin
            state_reg     <= LD_IDLE;
            byte_cnt_reg  <= 2'd0;
            len_phase_reg <= 1'b1;
            shift_reg     <= 32'h0;
            len_reg       <= 32'h0;
            word_cnt_reg  <= 32'h0;
            checksum_reg  <= 8'h0;
            tx_byte_reg   <= 8'h0;
            echo_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            resume_reg    <= ACT_RX;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            len_phase_reg <= len_phase_next;
            shift_reg     <= shift_next;
            len_reg       <= len_next;
            word_cnt_reg  <= word_cnt_next;
            checksum_reg  <= checksum_next;
            tx_byte_reg   <= tx_byte_next;
            echo_reg      <= echo_next;
            fail_reg      <= fail_next;
            resume_reg    <= resume_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        len_phase_next = len_phase_reg;
        shift_next     = shift_reg;
        len_next       = len_reg;
        word_cnt_next  = word_cnt_reg;
        checksum_next  = checksum_reg;
        tx_byte_next   = tx_byte_reg;
        echo_next      = echo_reg;
        fail_next      = fail_reg;
        resume_next    = resume_reg;
        error_next     = error_reg;
        rx_act         = ACT_RX;
        act            = ACT_RX;
        dispatch_en    = 1'b0;

        case (state_reg)
            LD_RX: begin
                if (rx_ack) begin
                    // Bytes arrive little-endian, so shifting in from the top leaves word[7:0] = first byte.
                    shift_next    = {rx_byte, shift_reg[31:8]};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (len_phase_reg) begin
                        if (byte_cnt_reg == 2'd3) begin
                            len_next       = shift_next;
                            len_phase_next = 1'b0;
                            if (shift_next > MAX_WORDS) begin
                                rx_act = ACT_TX_ERR;
                            end else if (shift_next == 32'h0) begin
                                rx_act = ACT_TX_SUM;
                            end
                        end
                    end else begin
                        checksum_next = checksum_reg + rx_byte;
                        if (byte_cnt_reg == 2'd3) begin
                            rx_act = ACT_RAM_WR;
                        end
                    end
                    if (ECHO_EN) begin
                        state_next   = LD_TX;
                        tx_byte_next = rx_byte;
                        echo_next    = 1'b1;
                        resume_next  = rx_act;
                    end else begin
                        dispatch_en = 1'b1;
                        act         = rx_act;
                    end
                end
            end
            LD_RAM_WR: begin
                word_cnt_next = word_cnt_reg + 32'd1;
                dispatch_en   = 1'b1;
                act           = (word_cnt_next == len_reg) ? ACT_TX_SUM : ACT_RX;
            end
            LD_TX: begin
                if (tx_ack) begin
                    if (echo_reg) begin
                        echo_next   = 1'b0;
                        dispatch_en = 1'b1;
                        act         = resume_reg;
                    end else if (fail_reg) begin
                        state_next = LD_ERROR;
                        error_next = 1'b1;
                    end else begin
                        state_next = LD_DONE;
                    end
                end
            end
            LD_DONE, LD_ERROR: begin
                state_next = LD_IDLE;
            end
            default: begin
            end
        endcase

        if (dispatch_en) begin
            case (act)
                ACT_RX: begin
                    state_next = LD_RX;
                end
                ACT_RAM_WR: begin
                    state_next = LD_RAM_WR;
                end
                ACT_TX_SUM: begin
                    state_next   = LD_TX;
                    tx_byte_next = checksum_next;
                end
                ACT_TX_ERR: begin
                    state_next   = LD_TX;
                    tx_byte_next = ERR_BYTE;
                    fail_next    = 1'b1;
                end
                default: begin
                end
            endcase
        end

        if (!busy && start) begin
            state_next     = LD_RX;
            byte_cnt_next  = 2'd0;
            len_phase_next = 1'b1;
            shift_next     = 32'h0;
            len_next       = 32'h0;
            word_cnt_next  = 32'h0;
            checksum_next  = 8'h0;
            echo_next      = 1'b0;
            fail_next      = 1'b0;
            error_next     = 1'b0;
        end
    end

endmodule
